// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory load port, redirect, and the
// valid/ready fetch queue head presented to decode.
interface fetch_unit_if #(
  parameter int ADDR_W   = 8,
  parameter int FQ_DEPTH = 4
);
  logic                      imem_we;
  logic [ADDR_W-1:0]         imem_waddr;
  logic [31:0]               imem_wdata;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_instr;
  logic [31:0]               out_pc;
  logic                      fetch_halted;
  logic [$clog2(FQ_DEPTH):0] fq_count;

  // Driver side (decode / loader / branch unit)
  modport master (
    output imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, out_ready,
    input  out_valid, out_instr, out_pc, fetch_halted, fq_count
  );

  // Fetch unit side
  modport slave (
    input  imem_we, imem_waddr, imem_wdata, redirect_valid, redirect_pc, out_ready,
    output out_valid, out_instr, out_pc, fetch_halted, fq_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous-read instruction memory with a
// load port, and a small {pc, instr} queue feeding decode. Issue is
// credit-limited so a returning read always finds room in the queue.
module fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.slave bus
);
  localparam int QW = $clog2(FQ_DEPTH);
  localparam int CW = QW + 1;

  logic [31:0]   r_mem [2**ADDR_W];
  logic [31:0]   r_rdata;
  logic [31:0]   r_pc;
  logic [31:0]   r_inflight_pc;
  logic          r_inflight;
  logic          r_halted;
  logic [31:0]   r_fq_pc    [FQ_DEPTH];
  logic [31:0]   r_fq_instr [FQ_DEPTH];
  logic [QW-1:0] r_wptr;
  logic [QW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [ADDR_W-1:0] w_ridx;
  logic [CW:0]       w_occ;
  logic              w_redir;
  logic              w_ret_zero;
  logic              w_push;
  logic              w_halt;
  logic              w_issue;
  logic              w_pop;
  logic              w_valid;

  // Issue / return / pop decisions; redirect suppresses all of them
  always_comb begin
    w_redir    = bus.redirect_valid;
    w_ridx     = r_pc[ADDR_W+1:2];
    // occupancy counts the in-flight read so the queue can never overflow
    w_occ      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_ret_zero = (r_rdata == 32'h0);
    w_push     = r_inflight & ~w_ret_zero & ~w_redir;
    w_halt     = r_inflight &  w_ret_zero & ~w_redir;
    // a read that would issue on the halting edge is dropped here
    w_issue    = ~r_halted & ~w_redir & ~w_halt & (w_occ < (CW+1)'(FQ_DEPTH));
    w_valid    = (r_count != '0);
    w_pop      = w_valid & bus.out_ready & ~w_redir;
  end

  // Memory write port; a same-cycle read of the same word sees old data
  always_ff @(posedge clk) begin
    if (bus.imem_we) r_mem[bus.imem_waddr] <= bus.imem_wdata;
  end

  // Registered read; the data only matters when r_inflight marks it live
  always_ff @(posedge clk) begin
    if (w_issue) r_rdata <= r_mem[w_ridx];
  end

  // Queue storage; pointers and count live in the control block
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fq_pc[r_wptr]    <= r_inflight_pc;
      r_fq_instr[r_wptr] <= r_rdata;
    end
  end

  // PC, in-flight tracking, halt flag and queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_halted      <= 1'b0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else if (w_redir) begin
      r_pc       <= bus.redirect_pc & ~32'h3;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + 32'd4;
      end
      // park the PC on the zero word so a later resume is well defined
      if (w_halt) begin
        r_halted <= 1'b1;
        r_pc     <= r_inflight_pc;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation; zeros when the queue is empty
  always_comb begin
    bus.out_valid    = w_valid;
    bus.out_instr    = w_valid ? r_fq_instr[r_rptr] : 32'h0;
    bus.out_pc       = w_valid ? r_fq_pc[r_rptr]    : 32'h0;
    bus.fetch_halted = r_halted;
    bus.fq_count     = r_count;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table for the basic program run,
// then hand-written sequences for stall, redirect, resume, reset and
// write/read collision.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [63:0] dq [$];

  fetch_unit_if #(.ADDR_W(8), .FQ_DEPTH(4)) bus ();

  fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halt;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.imem_we = 1'b1; bus.imem_waddr = a; bus.imem_wdata = d;
    tick();
    bus.imem_we = 1'b0;
  endtask

  // Record each head that will pop at the next edge (out_ready held high)
  task automatic collect(input int cycles);
    dq.delete();
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.out_valid) dq.push_back({bus.out_pc, bus.out_instr});
      tick();
    end
  endtask

  task automatic chk_entry(input string name, input int idx, input logic [31:0] pc,
                           input logic [31:0] instr);
    if (dq.size() > idx) begin
      chk({name, "_pc"},    dq[idx][63:32], pc);
      chk({name, "_instr"}, dq[idx][31:0],  instr);
    end else begin
      chk({name, "_present"}, 32'(dq.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;

    // program preload while held in reset
    wr(8'd0, 32'h09a06293);
    wr(8'd1, 32'h00106313);
    wr(8'd2, 32'h00730e33);
    wr(8'd3, 32'h01ce0eb3);
    wr(8'd4, 32'h00000000);

    // ---- scenario 1: straight-line run to halt, one record per edge
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 3'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        1'b0, 3'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h09a06293, 1'b0, 3'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h4, 32'h00106313, 1'b0, 3'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h8, 32'h00730e33, 1'b0, 3'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'hC, 32'h01ce0eb3, 1'b0, 3'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 3'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 3'd0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 3'd0};
    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst;
      bus.out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("s1_v%0d_valid", i), 32'(bus.out_valid),    32'(tbl[i].vld));
      chk($sformatf("s1_v%0d_pc", i),    bus.out_pc,            tbl[i].pc);
      chk($sformatf("s1_v%0d_instr", i), bus.out_instr,         tbl[i].instr);
      chk($sformatf("s1_v%0d_halt", i),  32'(bus.fetch_halted), 32'(tbl[i].halt));
      chk($sformatf("s1_v%0d_cnt", i),   32'(bus.fq_count),     32'(tbl[i].cnt));
    end

    // ---- scenario 4: patch the halt word and resume by redirect
    wr(8'd4, 32'h00000013);
    wr(8'd5, 32'h00100093);
    wr(8'd6, 32'h00000000);
    chk("s4_still_halted", 32'(bus.fetch_halted), 32'd1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h10;
    tick();
    bus.redirect_valid = 1'b0;
    chk("s4_halt_clear", 32'(bus.fetch_halted), 32'd0);
    chk("s4_valid_low",  32'(bus.out_valid),    32'd0);
    collect(8);
    chk("s4_count", 32'(dq.size()), 32'd2);
    chk_entry("s4_e0", 0, 32'h10, 32'h00000013);
    chk_entry("s4_e1", 1, 32'h14, 32'h00100093);
    chk("s4_rehalt", 32'(bus.fetch_halted), 32'd1);
    wr(8'd4, 32'h00000000);

    // ---- scenario 2: decode stalled, queue must saturate at depth
    reset = 1'b1; bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fq_count > 3'd4) chk("s2_cnt_le4", 32'(bus.fq_count), 32'd4);
      if (bus.out_valid) chk("s2_head_pc", bus.out_pc, 32'h0);
    end
    chk("s2_cnt_sat",   32'(bus.fq_count), 32'd4);
    chk("s2_head_instr", bus.out_instr,    32'h09a06293);
    collect(12);
    chk("s2_count", 32'(dq.size()), 32'd4);
    chk_entry("s2_e0", 0, 32'h0, 32'h09a06293);
    chk_entry("s2_e1", 1, 32'h4, 32'h00106313);
    chk_entry("s2_e2", 2, 32'h8, 32'h00730e33);
    chk_entry("s2_e3", 3, 32'hC, 32'h01ce0eb3);
    chk("s2_halted", 32'(bus.fetch_halted), 32'd1);

    // ---- scenario 3: redirect to a misaligned target while fetching 0x8
    reset = 1'b1; bus.out_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h6;
    tick();
    bus.redirect_valid = 1'b0;
    chk("s3_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("s3_flush_cnt",   32'(bus.fq_count),  32'd0);
    tick();
    chk("s3_gap_valid",   32'(bus.out_valid), 32'd0);
    collect(10);
    chk("s3_count", 32'(dq.size()), 32'd3);
    chk_entry("s3_e0", 0, 32'h4, 32'h00106313);
    chk_entry("s3_e1", 1, 32'h8, 32'h00730e33);
    chk_entry("s3_e2", 2, 32'hC, 32'h01ce0eb3);

    // ---- scenario 5: reset mid-stream with three queued entries
    reset = 1'b1; bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("s5_cnt3", 32'(bus.fq_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s5_valid", 32'(bus.out_valid), 32'd0);
    chk("s5_cnt0",  32'(bus.fq_count),  32'd0);
    collect(10);
    chk("s5_count", 32'(dq.size()), 32'd4);
    chk_entry("s5_e0", 0, 32'h0, 32'h09a06293);

    // ---- scenario 6: write word 1 on the edge that reads it
    reset = 1'b1; bus.out_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.imem_we = 1'b1; bus.imem_waddr = 8'd1; bus.imem_wdata = 32'h00200313;
    tick();
    bus.imem_we = 1'b0;
    collect(10);
    chk_entry("s6_old", 1, 32'h4, 32'h00106313);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h4;
    tick();
    bus.redirect_valid = 1'b0;
    collect(10);
    chk_entry("s6_new", 0, 32'h4, 32'h00200313);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
